// File: rtl/mmu_route_split3.sv
// 1-to-3 router for the MMU request path: decodes a 2-bit destination field,
// forwards one drive/free transaction to the selected port and returns free upstream.
module mmu_route_split3 #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 128,
  parameter int SEL_LSB    = 126,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_drive0,
  output logic                  o_drive1,
  output logic                  o_drive2,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic [DATA_WIDTH-1:0] o_data2,
  input  logic                  i_free0,
  input  logic                  i_free1,
  input  logic                  i_free2,
  output logic                  o_err_sel,
  output logic                  o_timeout,
  output logic [7:0]            o_err_cnt
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, ACK, DROP} state_t;

  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t                  state, next_state;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [1:0]              sel_reg;
  logic [7:0]              wait_cnt, wait_cnt_next;
  logic [NUM_PORTS-1:0]    free_vec, sel_onehot;
  logic                    sel_free, stray_free, stray_drive, timeout_hit, err_event;
  logic                    busy_data;

  assign free_vec   = {i_free2, i_free1, i_free0};
  assign sel_onehot = (sel_reg == 2'd0) ? 3'b001 :
                      (sel_reg == 2'd1) ? 3'b010 :
                      (sel_reg == 2'd2) ? 3'b100 : 3'b000;

  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    sel_free      = 1'b0;
    stray_free    = 1'b0;
    stray_drive   = 1'b0;
    timeout_hit   = 1'b0;
    if (state == DRIVE || state == WAIT) begin
      sel_free   = |(free_vec & sel_onehot);
      stray_free = |(free_vec & ~sel_onehot);
    end else begin
      stray_free = |free_vec;
    end
    if (state != IDLE) stray_drive = i_drive;
    unique case (state)
      IDLE: if (i_drive) next_state = (i_data[SEL_LSB+:2] == 2'd3) ? DROP : DRIVE;
      DRIVE: begin
        wait_cnt_next = 8'd0;
        next_state    = sel_free ? ACK : WAIT;
      end
      WAIT: begin
        if (sel_free) begin
          next_state = ACK;
        end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          next_state  = ACK;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      ACK:  next_state = IDLE;
      DROP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // All error sources in one cycle collapse into a single count increment.
    err_event = stray_free | stray_drive | timeout_hit | (state == DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_reg  <= '0;
      sel_reg   <= 2'd0;
      wait_cnt  <= 8'd0;
      o_timeout <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (state == IDLE && i_drive) begin
        data_reg <= i_data;
        sel_reg  <= i_data[SEL_LSB+:2];
      end
      if (timeout_hit) o_timeout <= 1'b1;
      if (err_event && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  // Payload is presented for the whole transaction so a slow consumer sees it stable.
  assign busy_data = (state == DRIVE) || (state == WAIT) || (state == ACK);
  assign o_drive0  = (state == DRIVE) && (sel_reg == 2'd0);
  assign o_drive1  = (state == DRIVE) && (sel_reg == 2'd1);
  assign o_drive2  = (state == DRIVE) && (sel_reg == 2'd2);
  assign o_data0   = (busy_data && sel_reg == 2'd0) ? data_reg : '0;
  assign o_data1   = (busy_data && sel_reg == 2'd1) ? data_reg : '0;
  assign o_data2   = (busy_data && sel_reg == 2'd2) ? data_reg : '0;
  assign o_free    = (state == ACK) || (state == DROP);
  assign o_err_sel = (state == DROP);

endmodule

// File: tb/tb_mmu_route_split3.sv
// Directed bench for mmu_route_split3 with TIMEOUT=4; routed transactions are
// scoreboarded and checked when the DUT issues the downstream drive.
module tb_mmu_route_split3;

  logic         clk;
  logic         rst;
  logic         i_drive;
  logic [127:0] i_data;
  logic         o_free, o_drive0, o_drive1, o_drive2;
  logic [127:0] o_data0, o_data1, o_data2;
  logic         i_free0, i_free1, i_free2;
  logic         o_err_sel, o_timeout;
  logic [7:0]   o_err_cnt;

  typedef struct {
    int           port;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] payload;

  mmu_route_split3 #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2),
    .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
    .i_free0(i_free0), .i_free1(i_free1), .i_free2(i_free2),
    .o_err_sel(o_err_sel), .o_timeout(o_timeout), .o_err_cnt(o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are pulses: every cycle starts with them cleared, 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    i_drive = 1'b0;
    i_free0 = 1'b0;
    i_free1 = 1'b0;
    i_free2 = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] sel, output logic [127:0] word);
    exp_t e;
    word = {$urandom, $urandom, $urandom, $urandom};
    word[127:126] = sel;
    i_data  = word;
    i_drive = 1'b1;
    if (sel != 2'd3) begin
      e.port = int'(sel);
      e.data = word;
      sb.push_back(e);
    end
  endtask

  task automatic expectDrive();
    exp_t         e;
    int           port;
    logic [127:0] d;
    port = o_drive0 ? 0 : o_drive1 ? 1 : o_drive2 ? 2 : -1;
    d    = (port == 0) ? o_data0 : (port == 1) ? o_data1 : (port == 2) ? o_data2 : '0;
    checkOutput("drive_count", 128'(o_drive0) + 128'(o_drive1) + 128'(o_drive2), 128'd1);
    checkOutput("sb_pending", 128'(sb.size() != 0), 128'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("drive_port", 128'(port), 128'(e.port));
      checkOutput("drive_data", d, e.data);
    end
  endtask

  initial begin
    rst = 1'b0; i_drive = 1'b0; i_data = '0;
    i_free0 = 1'b0; i_free1 = 1'b0; i_free2 = 1'b0;
    payload = '0;

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_free", 128'(o_free), 128'd0);
    checkOutput("rst_drives", {o_drive2, o_drive1, o_drive0}, 128'd0);
    checkOutput("rst_data", o_data0 | o_data1 | o_data2, 128'd0);
    checkOutput("rst_errcnt", 128'(o_err_cnt), 128'd0);
    checkOutput("rst_timeout", 128'(o_timeout), 128'd0);

    $display("[TB] port 1 with free 3 cycles after drive");
    applyStimulus(2'd1, payload);
    tick();
    expectDrive();
    checkOutput("p1_free_t1", 128'(o_free), 128'd0);
    tick();
    checkOutput("p1_wait_data", o_data1, payload);
    checkOutput("p1_wait_drive", 128'(o_drive1), 128'd0);
    tick();
    tick();
    i_free1 = 1'b1;
    tick();
    checkOutput("p1_free_t5", 128'(o_free), 128'd1);
    checkOutput("p1_ack_data", o_data1, payload);
    checkOutput("p1_other_data", o_data0 | o_data2, 128'd0);
    tick();
    checkOutput("p1_free_t6", 128'(o_free), 128'd0);
    checkOutput("p1_idle_data", o_data1, 128'd0);
    checkOutput("p1_errcnt", 128'(o_err_cnt), 128'd0);

    $display("[TB] zero-delay consumer and back-to-back request");
    doReset();
    applyStimulus(2'd0, payload);
    tick();
    expectDrive();
    i_free0 = 1'b1;
    tick();
    checkOutput("zd_free_t2", 128'(o_free), 128'd1);
    tick();
    checkOutput("zd_free_t3", 128'(o_free), 128'd0);
    applyStimulus(2'd2, payload);
    tick();
    expectDrive();
    i_free2 = 1'b1;
    tick();
    checkOutput("b2b_free", 128'(o_free), 128'd1);
    tick();
    checkOutput("b2b_errcnt", 128'(o_err_cnt), 128'd0);

    $display("[TB] bad destination");
    doReset();
    applyStimulus(2'd3, payload);
    tick();
    checkOutput("drop_err_sel", 128'(o_err_sel), 128'd1);
    checkOutput("drop_free", 128'(o_free), 128'd1);
    checkOutput("drop_drives", {o_drive2, o_drive1, o_drive0}, 128'd0);
    tick();
    checkOutput("drop_err_sel_off", 128'(o_err_sel), 128'd0);
    checkOutput("drop_errcnt", 128'(o_err_cnt), 128'd1);

    $display("[TB] timeout on port 2");
    doReset();
    applyStimulus(2'd2, payload);
    tick();
    expectDrive();
    for (int c = 2; c <= 5; c++) begin
      tick();
      checkOutput($sformatf("to_nofree_t%0d", c), 128'(o_free), 128'd0);
    end
    tick();
    checkOutput("to_free_t6", 128'(o_free), 128'd1);
    checkOutput("to_flag", 128'(o_timeout), 128'd1);
    checkOutput("to_errcnt1", 128'(o_err_cnt), 128'd1);
    tick();
    i_free2 = 1'b1;
    tick();
    tick();
    checkOutput("to_errcnt2", 128'(o_err_cnt), 128'd2);
    checkOutput("to_sticky", 128'(o_timeout), 128'd1);
    checkOutput("to_late_free", 128'(o_free), 128'd0);

    $display("[TB] ignored drive and stray free during WAIT");
    doReset();
    applyStimulus(2'd1, payload);
    tick();
    expectDrive();
    tick();
    i_data  = ~payload;
    i_drive = 1'b1;
    tick();
    i_free0 = 1'b1;
    tick();
    i_free1 = 1'b1;
    tick();
    checkOutput("ign_free", 128'(o_free), 128'd1);
    checkOutput("ign_data", o_data1, payload);
    tick();
    checkOutput("ign_errcnt", 128'(o_err_cnt), 128'd2);
    checkOutput("ign_timeout", 128'(o_timeout), 128'd0);

    $display("[TB] reset during WAIT, recovery and saturation");
    applyStimulus(2'd0, payload);
    tick();
    expectDrive();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_outputs", {o_free, o_drive2, o_drive1, o_drive0, o_err_sel, o_timeout}, 128'd0);
    checkOutput("midrst_data", o_data0 | o_data1 | o_data2, 128'd0);
    checkOutput("midrst_errcnt", 128'(o_err_cnt), 128'd0);
    tick();
    checkOutput("midrst_nofree", 128'(o_free), 128'd0);
    applyStimulus(2'd1, payload);
    tick();
    expectDrive();
    i_free1 = 1'b1;
    tick();
    checkOutput("rec_free", 128'(o_free), 128'd1);
    tick();
    for (int n = 1; n <= 300; n++) begin
      applyStimulus(2'd3, payload);
      tick();
      tick();
      if (n == 100) checkOutput("sat_mid", 128'(o_err_cnt), 128'd100);
    end
    checkOutput("sat_errcnt", 128'(o_err_cnt), 128'd255);
    checkOutput("sb_drained", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
